// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - opcode/func constants, control encodings and state encoding for mc_controller
package mc_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;

   localparam logic [2:0] NPC_PC4 = 3'd0;
   localparam logic [2:0] NPC_BEQ = 3'd1;
   localparam logic [2:0] NPC_J   = 3'd2;
   localparam logic [2:0] NPC_JR  = 3'd3;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_OR  = 5'd2;
   localparam logic [4:0] ALU_SLL = 5'd3;
   localparam logic [4:0] ALU_LUI = 5'd4;

   localparam logic [2:0] WD_DM  = 3'd0;
   localparam logic [2:0] WD_ALU = 3'd1;
   localparam logic [2:0] WD_PC4 = 3'd2;

   localparam logic [2:0] WRA3_RD = 3'd0;
   localparam logic [2:0] WRA3_RT = 3'd1;
   localparam logic [2:0] WRA3_RA = 3'd2;

   localparam logic [2:0] DM_WORD = 3'd0;
   localparam logic [2:0] DM_BYTE = 3'd1;

   localparam logic [2:0] ALUB_RT  = 3'd0;
   localparam logic [2:0] ALUB_IMM = 3'd1;

   typedef enum logic [4:0] {
      S_FETCH  = 5'b00001,
      S_DECODE = 5'b00010,
      S_EXEC   = 5'b00100,
      S_MEM    = 5'b01000,
      S_WB     = 5'b10000
   } state_e;

   typedef struct packed {
      logic r_alu;
      logic ori;
      logic lui;
      logic load;
      logic store;
      logic beq;
      logic j;
      logic jal;
      logic jr;
      logic jalr;
      logic byte_acc;
      logic illegal;
   } instr_class_t;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction/data memory request and ready handshake
interface mc_controller_if;

   logic       im_req;
   logic       im_ready;
   logic       dm_req;
   logic       dm_ready;
   logic       dm_wr_en;
   logic [2:0] dm_op;

   modport master (output im_req, dm_req, dm_wr_en, dm_op, input im_ready, dm_ready);
   modport slave  (input im_req, dm_req, dm_wr_en, dm_op, output im_ready, dm_ready);

endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/func to instruction-class decode
module mc_decode
   import mc_defs::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   func,
   output instr_class_t cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               FN_ADD, FN_SUB, FN_SLL: cls.r_alu = 1'b1;
               FN_JR:                  cls.jr    = 1'b1;
               FN_JALR:                cls.jalr  = 1'b1;
               default:                cls.illegal = 1'b1;
            endcase
         end
         OP_ORI: cls.ori  = 1'b1;
         OP_LUI: cls.lui  = 1'b1;
         OP_LW:  cls.load = 1'b1;
         OP_LB: begin
            cls.load     = 1'b1;
            cls.byte_acc = 1'b1;
         end
         OP_SW:  cls.store = 1'b1;
         OP_SB: begin
            cls.store    = 1'b1;
            cls.byte_acc = 1'b1;
         end
         OP_BEQ: cls.beq = 1'b1;
         OP_J:   cls.j   = 1'b1;
         OP_JAL: cls.jal = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit
// Optional cycle/instruction counters under MC_PERF_CNT_EN.
module mc_controller
   import mc_defs::*;
`ifdef MC_PERF_CNT_EN
   #(parameter int PERF_W = 32)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   mc_controller_if.master mem,
   output logic       ir_wr_en,
   output logic       pc_wr_en,
   output logic [2:0] npc_op,
   output logic       grf_wr_en,
   output logic [2:0] wra3_sel,
   output logic [2:0] wd_sel,
   output logic [4:0] alu_op,
   output logic [2:0] alub_sel,
   output logic       ext_op,
   output logic       sll_op,
   output logic       busy
`ifdef MC_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instr_cnt
`endif
);

   state_e       state_q, state_d;
   instr_class_t cls;
   logic         im_req, dm_req, dm_wr_en;
   logic [2:0]   dm_op;

   mc_decode u_decode (.opcode(opcode), .func(func), .cls(cls));

   // Outputs are gated by reset so an aborted instruction drops its enables at once.
   always_comb begin
      state_d   = state_q;
      im_req    = 1'b0;
      ir_wr_en  = 1'b0;
      dm_req    = 1'b0;
      dm_wr_en  = 1'b0;
      dm_op     = DM_WORD;
      pc_wr_en  = 1'b0;
      npc_op    = NPC_PC4;
      grf_wr_en = 1'b0;
      wra3_sel  = WRA3_RD;
      wd_sel    = WD_DM;
      alu_op    = ALU_ADD;
      alub_sel  = ALUB_RT;
      ext_op    = 1'b0;
      sll_op    = 1'b0;
      busy      = 1'b0;
      if (!reset) begin
         busy = (state_q != S_FETCH);
         case (state_q)
            S_FETCH: begin
               im_req = 1'b1;
               if (mem.im_ready) begin
                  ir_wr_en = 1'b1;
                  state_d  = S_DECODE;
               end
            end
            S_DECODE: begin
               state_d = S_FETCH;
               if (cls.j || cls.jal) begin
                  pc_wr_en = 1'b1;
                  npc_op   = NPC_J;
               end else if (cls.jr || cls.jalr) begin
                  pc_wr_en = 1'b1;
                  npc_op   = NPC_JR;
               end else if (cls.illegal) begin
                  pc_wr_en = 1'b1;
               end else begin
                  state_d = S_EXEC;
               end
               if (cls.jal || cls.jalr) begin
                  grf_wr_en = 1'b1;
                  wra3_sel  = cls.jal ? WRA3_RA : WRA3_RD;
                  wd_sel    = WD_PC4;
               end
            end
            S_EXEC: begin
               if (cls.beq) begin
                  pc_wr_en = 1'b1;
                  npc_op   = zero ? NPC_BEQ : NPC_PC4;
                  state_d  = S_FETCH;
               end else if (cls.load || cls.store) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               dm_req   = 1'b1;
               dm_op    = cls.byte_acc ? DM_BYTE : DM_WORD;
               dm_wr_en = cls.store;
               if (mem.dm_ready) begin
                  if (cls.store) begin
                     pc_wr_en = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
            S_WB: begin
               grf_wr_en = 1'b1;
               pc_wr_en  = 1'b1;
               state_d   = S_FETCH;
               if (cls.load) begin
                  wd_sel   = WD_DM;
                  wra3_sel = WRA3_RT;
               end else if (cls.ori || cls.lui) begin
                  wd_sel   = WD_ALU;
                  wra3_sel = WRA3_RT;
               end else begin
                  wd_sel   = WD_ALU;
                  wra3_sel = WRA3_RD;
               end
            end
            default: state_d = S_FETCH;
         endcase

         // ALU controls stay up through MEM and WB so address/result remain valid.
         if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            if (cls.r_alu) begin
               alu_op = (func == FN_SUB) ? ALU_SUB : (func == FN_SLL) ? ALU_SLL : ALU_ADD;
               sll_op = (func == FN_SLL);
            end else if (cls.ori) begin
               alu_op   = ALU_OR;
               alub_sel = ALUB_IMM;
            end else if (cls.lui) begin
               alu_op   = ALU_LUI;
               alub_sel = ALUB_IMM;
            end else if (cls.load || cls.store) begin
               alub_sel = ALUB_IMM;
               ext_op   = 1'b1;
            end else if (cls.beq) begin
               alu_op = ALU_SUB;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign mem.im_req   = im_req;
   assign mem.dm_req   = dm_req;
   assign mem.dm_wr_en = dm_wr_en;
   assign mem.dm_op    = dm_op;

`ifdef MC_PERF_CNT_EN
   logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      instr_cnt_d = instr_cnt_q + {{(PERF_W-1){1'b0}}, pc_wr_en};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;
   import mc_defs::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, func;
   logic       zero;
   logic       ir_wr_en, pc_wr_en, grf_wr_en, ext_op, sll_op, busy;
   logic [2:0] npc_op, wra3_sel, wd_sel, alub_sel;
   logic [4:0] alu_op;
`ifdef MC_PERF_CNT_EN
   logic [3:0] cycle_cnt, instr_cnt;
`endif
   int n_chk = 0;
   int n_fail = 0;

   mc_controller_if mi ();

`ifdef MC_PERF_CNT_EN
   mc_controller #(.PERF_W(4)) dut (
`else
   mc_controller dut (
`endif
      .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero), .mem(mi),
      .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en), .npc_op(npc_op), .grf_wr_en(grf_wr_en),
      .wra3_sel(wra3_sel), .wd_sel(wd_sel), .alu_op(alu_op), .alub_sel(alub_sel),
      .ext_op(ext_op), .sll_op(sll_op), .busy(busy)
`ifdef MC_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Nibbles: {im_req,ir,dm_req,dm_wr} {0,dm_op} {pc,npc} {grf,wra3} {0,wd} {0,alub} {alu_op:8} {0,ext,sll,busy}
   logic [35:0] bundle;
   assign bundle = {mi.im_req, ir_wr_en, mi.dm_req, mi.dm_wr_en, 1'b0, mi.dm_op,
                    pc_wr_en, npc_op, grf_wr_en, wra3_sel, 1'b0, wd_sel, 1'b0, alub_sel,
                    3'b000, alu_op, 1'b0, ext_op, sll_op, busy};

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [35:0] exp);
      #1;
      chk(tag, bundle, exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      func   = fn;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; zero = 1'b0; set_ir(OP_RTYPE, FN_ADD);
      mi.im_ready = 1'b0; mi.dm_ready = 1'b0;
      @(negedge clk);
      cyc("reset.hold", 36'h0_0_0_0_0_0_00_0);

      // 1: reset aborts add in WB
      reset = 1'b0; mi.im_ready = 1'b1;
      cyc("add0.fetch",  36'hC_0_0_0_0_0_00_0);
      cyc("add0.decode", 36'h0_0_0_0_0_0_00_1);
      cyc("add0.exec",   36'h0_0_0_0_0_0_00_1);
      #1 chk("add0.wb", bundle, 36'h0_0_8_8_1_0_00_1);
      reset = 1'b1;
      #1 chk("reset.mid_wb", bundle, 36'h0_0_0_0_0_0_00_0);
      @(posedge clk); @(negedge clk);
      cyc("reset.hold2", 36'h0_0_0_0_0_0_00_0);
      reset = 1'b0;

      // 2: add, 4 cycles
      cyc("add.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("add.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("add.c3", 36'h0_0_0_0_0_0_00_1);
      cyc("add.c4", 36'h0_0_8_8_1_0_00_1);

      // 3: lw with 3 dm wait cycles, dm_ready ignored before MEM
      set_ir(OP_LW, 6'h00); mi.dm_ready = 1'b1;
      cyc("lw.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("lw.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("lw.c3", 36'h0_0_0_0_0_1_00_5);
      mi.dm_ready = 1'b0;
      cyc("lw.c4", 36'h2_0_0_0_0_1_00_5);
      cyc("lw.c5", 36'h2_0_0_0_0_1_00_5);
      cyc("lw.c6", 36'h2_0_0_0_0_1_00_5);
      mi.dm_ready = 1'b1;
      cyc("lw.c7", 36'h2_0_0_0_0_1_00_5);
      mi.dm_ready = 1'b0;
      cyc("lw.c8", 36'h0_0_8_9_0_1_00_5);

      // sb, zero wait
      set_ir(OP_SB, 6'h00); mi.dm_ready = 1'b1;
      cyc("sb.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("sb.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("sb.c3", 36'h0_0_0_0_0_1_00_5);
      cyc("sb.c4", 36'h3_1_8_0_0_1_00_5);
      mi.dm_ready = 1'b0;

      // 4: beq taken then not taken
      set_ir(OP_BEQ, 6'h00); zero = 1'b1;
      cyc("beq1.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("beq1.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("beq1.c3", 36'h0_0_9_0_0_0_01_1);
      zero = 1'b0;
      cyc("beq0.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("beq0.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("beq0.c3", 36'h0_0_8_0_0_0_01_1);

      // 5: jal, jalr, illegal
      set_ir(OP_JAL, 6'h00);
      cyc("jal.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("jal.c2", 36'h0_0_A_A_2_0_00_1);
      set_ir(OP_RTYPE, FN_JALR);
      cyc("jalr.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("jalr.c2", 36'h0_0_B_8_2_0_00_1);
      set_ir(6'b111111, 6'h00);
      cyc("ill.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("ill.c2", 36'h0_0_8_0_0_0_00_1);

      // ori with one im wait cycle, then sll
      set_ir(OP_ORI, 6'h00); mi.im_ready = 1'b0;
      cyc("ori.wait", 36'h8_0_0_0_0_0_00_0);
      mi.im_ready = 1'b1;
      cyc("ori.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("ori.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("ori.c3", 36'h0_0_0_0_0_1_02_1);
      cyc("ori.c4", 36'h0_0_8_9_1_1_02_1);
      set_ir(OP_RTYPE, FN_SLL);
      cyc("sll.c1", 36'hC_0_0_0_0_0_00_0);
      cyc("sll.c2", 36'h0_0_0_0_0_0_00_1);
      cyc("sll.c3", 36'h0_0_0_0_0_0_03_3);
      cyc("sll.c4", 36'h0_0_8_8_1_0_03_3);
      cyc("idle.fetch", 36'hC_0_0_0_0_0_00_0);

`ifdef MC_PERF_CNT_EN
      // 6: 20 nops with 4-bit counters
      reset = 1'b1; set_ir(6'b111111, 6'h00);
      #1 chk("perf.cyc_rst", {32'd0, cycle_cnt}, 36'd0);
      chk("perf.ins_rst", {32'd0, instr_cnt}, 36'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); @(negedge clk); #1;
         if (i == 30) chk("perf.ins_15", {32'd0, instr_cnt}, 36'd15);
         if (i == 32) chk("perf.ins_wrap", {32'd0, instr_cnt}, 36'd0);
      end
      chk("perf.ins_end", {32'd0, instr_cnt}, 36'd4);
      chk("perf.cyc_end", {32'd0, cycle_cnt}, 36'd8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
